// File: rtl/qupls_regfile_rdport_arb_if.sv
// Operand-request / read-port bundle between the decode stage and the
// register-file read-port arbiter.
interface qupls_regfile_rdport_arb_if #(
  parameter int NREQ  = 8,
  parameter int NPORT = 4,
  parameter int AWID  = 6,
  parameter int PW    = $clog2(NPORT)
);
  logic                  flush;
  logic [NREQ-1:0]       req_v;
  logic [NREQ*AWID-1:0]  req_reg;
  logic [NREQ-1:0]       req_gnt;
  logic                  stall;
  logic [NPORT-1:0]      port_v;
  logic [NPORT*AWID-1:0] port_addr;
  logic [NREQ-1:0]       rsp_v;
  logic [NREQ*PW-1:0]    rsp_port;
  logic [NREQ-1:0]       rsp_zero;

  modport master (
    output flush, req_v, req_reg,
    input  req_gnt, stall, port_v, port_addr, rsp_v, rsp_port, rsp_zero
  );

  modport slave (
    input  flush, req_v, req_reg,
    output req_gnt, stall, port_v, port_addr, rsp_v, rsp_port, rsp_zero
  );
endinterface

// File: rtl/qupls_regfile_rdport_arb.sv
// Register-file read-port arbiter: shares NPORT read ports among NREQ operand
// requesters with address sharing, free r0 reads and a rotating scan start.
module qupls_regfile_rdport_arb #(
  parameter int NREQ  = 8,
  parameter int NPORT = 4,
  parameter int AWID  = 6,
  parameter int PW    = $clog2(NPORT)
) (
  input logic                     clk,
  input logic                     rst,
  qupls_regfile_rdport_arb_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(NPORT + 1);

  logic [IW-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [NPORT-1:0]              port_v_q, port_v_d;
  logic [NPORT-1:0][AWID-1:0]    port_addr_q, port_addr_d;
  logic [NREQ-1:0]               rsp_v_q, rsp_v_d;
  logic [NREQ-1:0]               rsp_zero_q, rsp_zero_d;
  logic [NREQ-1:0][PW-1:0]       rsp_port_q, rsp_port_d;
  logic [NREQ-1:0]               gnt_c;
  logic                          stall_c;

  // Scan temporaries
  int                            pos;
  logic [IW-1:0]                 idx;
  logic [AWID-1:0]               rsel;
  logic                          hit;
  logic [PW-1:0]                 hit_port;
  logic [CW-1:0]                 used;
  logic                          denied;

  // Allocation happens in scan order from rr_ptr; ports are never released
  // within a cycle, so the count of used ports is also the lowest free index.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    port_v_d    = '0;
    port_addr_d = '0;
    rsp_zero_d  = '0;
    rsp_port_d  = '0;
    gnt_c       = '0;
    pos         = 0;
    idx         = '0;
    rsel        = '0;
    hit         = 1'b0;
    hit_port    = '0;
    used        = '0;
    denied      = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(rr_ptr_q) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      idx      = IW'(pos);
      rsel     = bus.req_reg[idx*AWID +: AWID];
      hit      = 1'b0;
      hit_port = '0;
      if (bus.req_v[idx] && !bus.flush) begin
        if (rsel == '0) begin
          gnt_c[idx]      = 1'b1;
          rsp_zero_d[idx] = 1'b1;
        end else begin
          for (int p = 0; p < NPORT; p++) begin
            if (!hit && port_v_d[p] && (port_addr_d[p] == rsel)) begin
              hit      = 1'b1;
              hit_port = PW'(p);
            end
          end
          if (hit) begin
            gnt_c[idx]      = 1'b1;
            rsp_port_d[idx] = hit_port;
          end else if (used < CW'(NPORT)) begin
            gnt_c[idx]                 = 1'b1;
            port_v_d[used[PW-1:0]]     = 1'b1;
            port_addr_d[used[PW-1:0]]  = rsel;
            rsp_port_d[idx]            = used[PW-1:0];
            used                       = used + CW'(1);
          end else if (!denied) begin
            // First loser leads the scan next cycle so it cannot starve
            denied   = 1'b1;
            rr_ptr_d = idx;
          end
        end
      end
    end
    rsp_v_d = gnt_c;
    stall_c = (|(bus.req_v & ~gnt_c)) && !bus.flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      port_v_q    <= '0;
      port_addr_q <= '0;
      rsp_v_q     <= '0;
      rsp_zero_q  <= '0;
      rsp_port_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      port_v_q    <= port_v_d;
      port_addr_q <= port_addr_d;
      rsp_v_q     <= rsp_v_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_port_q  <= rsp_port_d;
    end
  end

  assign bus.req_gnt   = gnt_c;
  assign bus.stall     = stall_c;
  assign bus.port_v    = port_v_q;
  assign bus.port_addr = port_addr_q;
  assign bus.rsp_v     = rsp_v_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_port  = rsp_port_q;
endmodule

// File: doc/qupls_regfile_rdport_arb.md
Name: qupls_regfile_rdport_arb

Overview:
Shares the register-file read ports among the decoded source-operand specifiers (Ra/Rb/Rc) of the instructions in the decode group. Each cycle it allocates requested register numbers to physical read ports. Requests for the same register share one port, and reads of r0 consume no port. It sits between the Ra/Rb/Rc decode stage and the register file. It drives the read-port addresses and tells each operand slot which port carries its data one cycle later.

Parameters:
NREQ, 8, number of operand requesters (decode slots × operands)
NPORT, 4, number of physical register-file read ports
AWID, 6, register specifier width (matches regspec_t)
PW, $clog2(NPORT), port index width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
flush  input  1  pipeline flush; suppresses all grants this cycle
req_v  input  NREQ  operand request valid, bit i = requester i
req_reg  input  NREQ*AWID  register number for requester i, slice [i*AWID +: AWID]
req_gnt  output  NREQ  combinational grant, same cycle as request
stall  output  1  combinational: some valid request not granted
port_v  output  NPORT  registered: read port p active
port_addr  output  NPORT*AWID  registered read-port register addresses
rsp_v  output  NREQ  registered: requester i's operand is available this cycle
rsp_port  output  NREQ*PW  registered: port index carrying requester i's operand
rsp_zero  output  NREQ  registered: requester i read r0; operand is zero, no port used

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: rr_ptr=0, port_v=0, port_addr=0, rsp_v=0, rsp_port=0, rsp_zero=0. req_gnt and stall are combinational and read 0 when req_v=0.
- Scan order: each cycle, requesters are examined in order rr_ptr, rr_ptr+1, …, wrapping modulo NREQ.
- Allocation rule for each valid requester i, in scan order:
  - If req_reg == 0: grant; rsp_zero[i]=1 next cycle; no port consumed.
  - Else, if req_reg equals an address already allocated this cycle: grant; share that port.
  - Else, if fewer than NPORT ports are allocated: allocate the lowest free port index and grant.
  - Else: deny.
- Port order: ports are assigned in ascending index, 0 first.
- stall = |(req_v & ~req_gnt). Denied requesters must hold req_v and req_reg stable until granted.
- Latency: a grant in cycle N produces, in cycle N+1:
  - port_addr/port_v for the allocated ports; unused ports have port_v=0 and port_addr=0;
  - rsp_v[i]=1, with rsp_port[i] and rsp_zero[i] valid.
  - rsp_v is 0 for requesters not granted in cycle N. rsp_port=0 when rsp_zero=1.
- rr_ptr update:
  - If any request is denied, rr_ptr takes the first denied requester in scan order.
  - Otherwise rr_ptr is unchanged.
  - This bounds wait time: a denied requester is first in scan order the next cycle, so it is granted within one extra cycle.
- flush=1: req_gnt=0 and stall=0 in that cycle; next cycle port_v=0 and rsp_v=0; rr_ptr is unchanged.
- rst dominates flush and any requests. A reset mid-stall discards pending allocation; the cycle after reset shows all registered outputs at 0.
- Duplicate requests that straddle the port limit: a duplicate of an already-allocated address is granted even when all ports are full.
- All-zero registers: if every request is r0, all are granted, port_v=0, and rsp_zero is set for each.

Test Plan:
- Reset: assert rst with req_v=8'hFF -> next cycle all registered outputs 0; req_gnt=0 while rst held is not required, but the cycle after reset release must show rr_ptr=0 behaviour.
- Distinct fit: req_v=8'h0F, regs 1,2,3,4 -> req_gnt=8'h0F, stall=0; next cycle port_addr={4,3,2,1}, port_v=4'hF, rsp_port[0..3]=0,1,2,3.
- Overflow: req_v=8'hFF, regs 1..8, rr_ptr=0 -> req_gnt=8'h0F, stall=1, rr_ptr becomes 4; with 4..7 still held, next cycle req_gnt=8'hF0, stall=0.
- Sharing and zero: req0=r5, req1=r5, req2=r0, req3=r9 -> all granted; next cycle port_addr[0]=5, port_addr[1]=9, port_v=4'b0011, rsp_port[1]=0, rsp_zero[2]=1.
- Wrap: rr_ptr=6, req_v on 6,7,0,1,2 with distinct regs -> 6,7,0,1 granted, 2 denied, rr_ptr becomes 2.
- Flush: flush=1 with req_v=8'h03 -> req_gnt=0, stall=0; next cycle rsp_v=0 and port_v=0; rr_ptr unchanged.
